// File: rtl/b11_stim_player.sv
// Stimulus sequencer and MISR response compactor for the b11 core.
// Replays a stored opcode program {obs, stbi, x_in[5:0]} and folds x_out into a 16-bit signature.
module b11_stim_player #(
  parameter int unsigned AW    = 6,
  parameter int unsigned DEPTH = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic [5:0]    x_out,
  output logic [5:0]    x_in,
  output logic          stbi,
  output logic          obs,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   pc,
  output logic [15:0]   sig
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  state_e      state_q;
  logic [AW:0] len_q;
  logic [AW:0] len_clamp;
  logic [15:0] sig_next;
  logic [7:0]  ram_rd;
  logic        fb;

  logic [7:0] ram [DEPTH];

  always_comb begin
    len_clamp = (len > DepthW) ? DepthW : len;
  end

  always_comb begin
    fb       = sig[15] ^ sig[14] ^ sig[12] ^ sig[3];
    sig_next = {sig[14:0], fb} ^ {10'b0, x_out};
  end

  // pc never exceeds len_q-1 while reading, so the low AW bits address the RAM without wrapping.
  always_comb begin
    ram_rd = ram[pc[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (load_en && (state_q == StIdle)) begin
      ram[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      pc      <= '0;
      sig     <= '0;
      x_in    <= '0;
      stbi    <= 1'b0;
      obs     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        // The DONE exit edge doubles as an IDLE decision point so back-to-back runs lose no cycle.
        StIdle, StDone: begin
          if (start) begin
            len_q <= len_clamp;
            pc    <= '0;
            sig   <= '0;
            busy  <= 1'b1;
            if (len_clamp == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end else begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          {obs, stbi, x_in} <= ram_rd;
          pc                <= pc + 1'b1;
          // The first RUN edge has no response yet; b11 answers one cycle late.
          if (pc != '0) begin
            sig <= sig_next;
          end
          if (pc == len_q - 1'b1) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          sig     <= sig_next;
          done    <= 1'b1;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_b11_stim_player.sv
// Directed self-checking bench for b11_stim_player (AW=6, DEPTH=64).
module tb_b11_stim_player;

  logic       clock;
  logic       reset;
  logic       load_en;
  logic [5:0] load_addr;
  logic [7:0] load_data;
  logic [6:0] len;
  logic       start;
  logic [5:0] x_out;
  logic [5:0] x_in;
  logic       stbi;
  logic       obs;
  logic       busy;
  logic       done;
  logic [6:0] pc;
  logic [15:0] sig;

  int n_vec;
  int n_err;
  logic [7:0]  mem [64];
  logic [15:0] exp_sig;

  b11_stim_player dut (
    .clock     (clock),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .len       (len),
    .start     (start),
    .x_out     (x_out),
    .x_in      (x_in),
    .stbi      (stbi),
    .obs       (obs),
    .busy      (busy),
    .done      (done),
    .pc        (pc),
    .sig       (sig)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic chk_op(input string tag, input logic [7:0] expected);
    chk(tag, {24'b0, obs, stbi, x_in}, {24'b0, expected});
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, done}, 32'd1);
    tick();
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [5:0] x);
    logic f;
    f = s[15] ^ s[14] ^ s[12] ^ s[3];
    return {s[14:0], f} ^ {10'b0, x};
  endfunction

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    len       = '0;
    start     = 1'b0;
    x_out     = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_outs", {busy, done, obs, stbi, x_in}, 32'd0);
    chk("reset_pc", pc, 0);
    chk("reset_sig", sig, 0);

    for (int i = 0; i < 64; i++) begin
      if (i == 0) mem[i] = 8'h81;
      else if (i == 1) mem[i] = 8'h42;
      else if (i == 2) mem[i] = 8'h3F;
      else mem[i] = 8'(i * 37 + 5);
    end
    load_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      load_addr = 6'(i);
      load_data = mem[i];
      tick();
    end
    load_en = 1'b0;

    // Basic replay, x_out = 0
    len   = 7'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_e0", busy, 1);
    tick();
    chk_op("t1_op0", 8'h81);
    tick();
    chk_op("t1_op1", 8'h42);
    tick();
    chk_op("t1_op2", 8'h3F);
    chk("t1_pc", pc, 3);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_sig", sig, 16'h0000);
    chk("t1_busy_done", busy, 1);
    tick();
    chk("t1_done_off", done, 0);
    chk("t1_busy_off", busy, 0);
    chk_op("t1_hold", 8'h3F);

    // MISR with constant x_out = 1
    x_out = 6'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t2_sig_e1", sig, 16'h0000);
    tick();
    chk("t2_sig_e2", sig, 16'h0001);
    tick();
    chk("t2_sig_e3", sig, 16'h0003);
    tick();
    chk("t2_sig_e4", sig, 16'h0007);
    chk("t2_done", done, 1);
    tick();
    chk("t2_sig_hold", sig, 16'h0007);

    // Zero length
    x_out = 6'h00;
    len   = 7'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 1);
    chk("t3_sig", sig, 0);
    chk_op("t3_outs", 8'h3F);
    tick();
    chk("t3_done_off", done, 0);
    chk("t3_busy_off", busy, 0);

    // Reset mid-run
    len   = 7'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk_op("t4_op2", 8'h3F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_rst_outs", {busy, done, obs, stbi, x_in}, 32'd0);
    chk("t4_rst_pc", pc, 0);
    chk("t4_rst_sig", sig, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_op("t4_restart_op0", 8'h81);
    wait_done("t4_finish");
    chk("t4_pc_final", pc, 10);

    // Ignored start and load during RUN
    len   = 7'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start     = 1'b1;
    load_en   = 1'b1;
    load_addr = 6'd1;
    load_data = 8'hFF;
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    chk_op("t5_op1", 8'h42);
    tick();
    chk_op("t5_op2", 8'h3F);
    tick();
    chk("t5_done", done, 1);
    tick();
    chk("t5_idle", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_op("t5_rerun_op1", 8'h42);
    wait_done("t5_rerun_finish");

    // Length clamp with start held high for back-to-back
    x_out   = 6'h2B;
    len     = 7'd127;
    exp_sig = 16'h0000;
    for (int i = 0; i < 64; i++) exp_sig = misr(exp_sig, 6'h2B);
    start = 1'b1;
    tick();
    chk("t6_busy_e0", busy, 1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk_op($sformatf("t6_op%0d", k - 1), mem[k - 1]);
    end
    chk("t6_pc", pc, 64);
    tick();
    chk("t6_done", done, 1);
    chk("t6_sig", sig, exp_sig);
    chk("t6_pc_sat", pc, 64);
    tick();
    start = 1'b0;
    chk("t6_b2b_sig", sig, 0);
    chk("t6_b2b_pc", pc, 0);
    chk("t6_b2b_busy", busy, 1);
    chk("t6_b2b_done", done, 0);
    tick();
    chk_op("t6_b2b_op0", 8'h81);
    wait_done("t6_b2b_finish");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
